// File: rtl/multi_pause_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_pause_pkg
// Purpose  : Shared definitions for the multi-channel pause stage: channel
//            FSM state encoding and the default debounce length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package multi_pause_pkg;

  // Default number of consecutive stable synchronized samples needed before
  // the debounced level follows the switch.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

  // Channel FSM state type and encoding. Encoding 2'd3 is unused and
  // recovers to sWait.
  typedef logic [1:0] state_t;
  localparam state_t sWait = 2'd0;
  localparam state_t sHigh = 2'd1;
  localparam state_t sDone = 2'd2;

endpackage : multi_pause_pkg
`default_nettype wire

// File: rtl/multi_pause_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce
// Purpose  : Two-flop synchronizer followed by a run-length debouncer for one
//            asynchronous switch input.
// Ports    : clk  - system clock
//            rst  - asynchronous active-low reset
//            in   - raw switch level, asynchronous to clk
//            out  - debounced level (registered)
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce
  import multi_pause_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching sample completes the run.
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any sample agreeing with the current level restarts the run; the level
  // only flips on the sample that would bring the run to DEBOUNCE_CYCLES.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == C_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out = deb_q;

endmodule : switch_debounce
`default_nettype wire

// File: rtl/multi_pause.sv
`default_nettype none
// ============================================================================
// Module   : multi_pause
// Purpose  : Multi-channel pause stage. Each channel commits once after a
//            clean, debounced high-then-low toggle of its switch, raising a
//            done flag and a single-cycle commit pulse. Optional re-arm.
// Ports    : clk         - system clock
//            rst         - asynchronous active-low reset
//            switchIn    - raw switch levels, one per channel
//            clear       - re-arm request (only honoured when STICKY=0)
//            toggle      - per-channel done flags (registered)
//            commitPulse - per-channel one-cycle commit pulse (registered)
//            anyDone     - OR of toggle
//            allDone     - AND of toggle
// Revision : 1.0 - initial release
// ============================================================================
module multi_pause
  import multi_pause_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          STICKY          = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] switchIn,
  input  logic                clear,
  output logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] commitPulse,
  output logic                anyDone,
  output logic                allDone
);

  logic [CHANNELS-1:0] deb;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    state_t state_q;
    logic   toggle_q;
    logic   pulse_q;

    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk(clk),
      .rst(rst),
      .in (switchIn[g]),
      .out(deb[g])
    );

    // Outputs are registered alongside the state so toggle and the commit
    // pulse change on the same edge as the sHigh -> sDone transition.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= sWait;
        toggle_q <= 1'b0;
        pulse_q  <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          sWait: begin
            if (deb[g]) begin
              state_q <= sHigh;
            end
          end
          sHigh: begin
            if (!deb[g]) begin
              state_q  <= sDone;
              toggle_q <= 1'b1;
              pulse_q  <= 1'b1;
            end
          end
          sDone: begin
            if (!STICKY && clear) begin
              state_q  <= sWait;
              toggle_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= sWait;
            toggle_q <= 1'b0;
          end
        endcase
      end
    end

    assign toggle[g]      = toggle_q;
    assign commitPulse[g] = pulse_q;
  end

  assign anyDone = |toggle;
  assign allDone = &toggle;

endmodule : multi_pause
`default_nettype wire

// File: tb/tb_multi_pause.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_pause
// Purpose  : Scoreboard bench for multi_pause. Two instances (re-arm and
//            sticky) share stimulus; a reference model predicts done flags
//            and commit pulses, a monitor compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_pause;

  localparam int CH = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [CH-1:0] switchIn;
  logic [CH-1:0] tog0, pul0, tog1, pul1;
  logic          any0, all0, any1, all1;

  always #5 clk = ~clk;

  multi_pause #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D), .STICKY(1'b0)) u_dut_s0 (
    .clk(clk), .rst(rst), .switchIn(switchIn), .clear(clear),
    .toggle(tog0), .commitPulse(pul0), .anyDone(any0), .allDone(all0)
  );

  multi_pause #(.CHANNELS(CH), .DEBOUNCE_CYCLES(D), .STICKY(1'b1)) u_dut_s1 (
    .clk(clk), .rst(rst), .switchIn(switchIn), .clear(clear),
    .toggle(tog1), .commitPulse(pul1), .anyDone(any1), .allDone(all1)
  );

  int checks = 0;
  int errors = 0;
  int ecount = 0;   // edges since start, counted while out of reset
  int e0;

  typedef struct {
    int          e;
    logic [CH-1:0] v0;
    logic [CH-1:0] v1;
  } exp_t;
  exp_t sbq[$];

  // Reference model: switch history per edge, debounced level, and per
  // instance (0: re-arm, 1: sticky) "done" and "seen high since arm" flags.
  logic [CH-1:0] hist [int];
  logic [CH-1:0] mdeb = '0;
  logic [CH-1:0] mdone [2] = '{default: '0};
  logic [CH-1:0] mseen [2] = '{default: '0};
  logic [CH-1:0] mp [2];
  logic [CH-1:0] s;
  bit            flip;

  // Level the debouncer sees at edge k: the switch sampled two edges earlier.
  function automatic logic [CH-1:0] synced_at(int k);
    return hist.exists(k - 2) ? hist[k - 2] : '0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdeb  = '0;
      mdone = '{default: '0};
      mseen = '{default: '0};
      hist.delete();
      sbq.delete();
    end else begin
      ecount++;
      hist[ecount] = switchIn;
      for (int m = 0; m < 2; m++) begin
        mp[m] = '0;
        for (int c = 0; c < CH; c++) begin
          if (mdone[m][c]) begin
            if (m == 0 && clear) begin
              mdone[m][c] = 1'b0;
              mseen[m][c] = 1'b0;
            end
          end else if (!mseen[m][c]) begin
            mseen[m][c] = mdeb[c];
          end else if (!mdeb[c]) begin
            mdone[m][c] = 1'b1;
            mp[m][c]    = 1'b1;
          end
        end
      end
      // Debounced level flips once D consecutive synced samples disagree.
      for (int c = 0; c < CH; c++) begin
        flip = 1'b1;
        for (int j = 0; j < D; j++) begin
          s = synced_at(ecount - j);
          if (s[c] == mdeb[c]) flip = 1'b0;
        end
        if (flip) mdeb[c] = ~mdeb[c];
      end
      if ((mp[0] | mp[1]) != '0) sbq.push_back('{ecount, mp[0], mp[1]});
    end
  end

  // Monitor: compare on the falling edge, away from the active edge.
  exp_t cur;
  bit   have;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].e < ecount) begin
      checks++; errors++;
      $display("FAIL pulse_missing edge %0d expected %h/%h got none", sbq[0].e, sbq[0].v0, sbq[0].v1);
      void'(sbq.pop_front());
    end
    have = (sbq.size() > 0 && sbq[0].e == ecount);
    if (have) cur = sbq.pop_front();
    else      cur = '{ecount, '0, '0};
    if (have || pul0 != '0 || pul1 != '0) begin
      checks++;
      if (pul0 !== cur.v0 || pul1 !== cur.v1) begin
        errors++;
        $display("FAIL commitPulse edge %0d got %h/%h expected %h/%h", ecount, pul0, pul1, cur.v0, cur.v1);
      end
    end
    checks++;
    if (tog0 !== mdone[0] || tog1 !== mdone[1]) begin
      errors++;
      $display("FAIL toggle edge %0d got %h/%h expected %h/%h", ecount, tog0, tog1, mdone[0], mdone[1]);
    end
    checks++;
    if (any0 !== (|mdone[0]) || any1 !== (|mdone[1])) begin
      errors++;
      $display("FAIL anyDone edge %0d got %b/%b expected %b/%b", ecount, any0, any1, |mdone[0], |mdone[1]);
    end
    checks++;
    if (all0 !== (&mdone[0]) || all1 !== (&mdone[1])) begin
      errors++;
      $display("FAIL allDone edge %0d got %b/%b expected %b/%b", ecount, all0, all1, &mdone[0], &mdone[1]);
    end
  end

  // Drive inputs 2 time units after each rising edge for n cycles.
  task automatic hold(input logic [CH-1:0] sw, input logic clr, input int n);
    for (int i = 0; i < n; i++) begin
      switchIn = sw;
      clear    = clr;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at edge %0d", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            got;
    logic [CH-1:0] sw;
    int            len;
    logic          clr;

    rst      = 1'b0;
    clear    = 1'b0;
    switchIn = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    hold(4'h0, 1'b0, 100);

    // Clean commit on ch0 with a directed latency check.
    hold(4'h1, 1'b0, 30);
    switchIn = 4'h0;
    e0  = ecount + 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (pul0[0]) got = 1'b1;
    end
    checks++;
    if (!got || (ecount - e0) != D + 2) begin
      errors++;
      $display("FAIL commit_latency got %0d edges (seen=%0d) expected %0d", ecount - e0, got, D + 2);
    end
    @(posedge clk);
    #2;
    hold(4'h0, 1'b0, 20);

    // Glitches on ch1 must not commit; the final clean low does.
    repeat (3) begin
      hold(4'h2, 1'b0, 15);
      hold(4'h0, 1'b0, 20);
    end
    hold(4'h2, 1'b0, 40);
    hold(4'h0, 1'b0, 15);
    hold(4'h2, 1'b0, 30);
    hold(4'h0, 1'b0, 30);

    // Re-arm, then all channels toggled together.
    hold(4'h0, 1'b1, 1);
    hold(4'h0, 1'b0, 5);
    hold(4'hF, 1'b0, 30);
    hold(4'h0, 1'b0, 30);

    // Re-arm and a second commit on ch2.
    hold(4'h0, 1'b1, 1);
    hold(4'h0, 1'b0, 5);
    hold(4'h4, 1'b0, 30);
    hold(4'h0, 1'b0, 30);

    // Reset while ch3 is mid-debounce of its falling edge.
    hold(4'h8, 1'b0, 30);
    hold(4'h0, 1'b0, 10);
    rst = 1'b0;
    hold(4'h0, 1'b0, 3);
    rst = 1'b1;
    hold(4'h0, 1'b0, 30);
    hold(4'h8, 1'b0, 30);
    hold(4'h0, 1'b0, 30);

    // Clear held high while switch stays high after re-arm.
    hold(4'h1, 1'b0, 30);
    hold(4'h1, 1'b1, 5);
    hold(4'h1, 1'b0, 5);
    hold(4'h0, 1'b0, 30);

    // Randomized segments.
    for (int k = 0; k < 150; k++) begin
      sw  = 4'($urandom);
      len = $urandom_range(1, 45);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        hold(sw, 1'b0, 2);
        rst = 1'b1;
      end
      hold(sw, clr, 1);
      hold(sw, 1'b0, len);
    end
    hold(4'h0, 1'b0, 40);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_pause
`default_nettype wire
